// File: rtl/vga_fb_pkg.sv
// rtl/vga_fb_pkg.sv - shared types and constants for the frame-buffer arbiter
package vga_fb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_WBUF,
        OWN_HRD
    } owner_t;

    localparam int STAT_W = 16;

endpackage

// File: rtl/vga_fb_wbuf.sv
// rtl/vga_fb_wbuf.sv - 1-entry posted-write buffer; load wins over drain
module vga_fb_wbuf #(
    parameter int AW = 10,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          drain,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          vld,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            addr <= wr_addr;
            data <= wr_data;
        end else if (drain) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - display/host arbiter for a 1RW frame-buffer RAM
// Optional stall statistics counter enabled by VGA_FB_ARB_STAT_EN.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_rvld,
    output logic [DW-1:0] disp_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic          host_rvld,
    output logic [DW-1:0] host_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
`ifdef VGA_FB_ARB_STAT_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_stall_cnt
`endif
);

    owner_t        owner;
    logic          wbuf_vld;
    logic [AW-1:0] wbuf_addr;
    logic [DW-1:0] wbuf_data;
    logic          wbuf_load;

    always_comb begin
        owner = OWN_NONE;
        if (disp_req)
            owner = OWN_DISP;
        else if (wbuf_vld)
            owner = OWN_WBUF;
        else if (host_req && !host_we)
            owner = OWN_HRD;
    end

    // A write may refill the buffer in the same cycle it drains, sustaining one write per cycle.
    always_comb begin
        host_ack = 1'b0;
        if (rst_n && host_req)
            host_ack = host_we ? (!wbuf_vld || owner == OWN_WBUF) : (owner == OWN_HRD);
        ram_we   = rst_n && (owner == OWN_WBUF);
        ram_din  = wbuf_data;
        ram_addr = disp_addr;
        if (owner == OWN_WBUF)
            ram_addr = wbuf_addr;
        else if (owner == OWN_HRD)
            ram_addr = host_addr;
    end

    assign wbuf_load  = host_ack && host_we;
    assign disp_rdata = ram_dout;
    assign host_rdata = ram_dout;

    vga_fb_wbuf #(.AW(AW), .DW(DW)) u_wbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (wbuf_load),
        .drain   (owner == OWN_WBUF),
        .wr_addr (host_addr),
        .wr_data (host_wdata),
        .vld     (wbuf_vld),
        .addr    (wbuf_addr),
        .data    (wbuf_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_rvld <= 1'b0;
            host_rvld <= 1'b0;
        end else begin
            disp_rvld <= (owner == OWN_DISP);
            host_rvld <= (owner == OWN_HRD);
        end
    end

`ifdef VGA_FB_ARB_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stat_stall_cnt <= '0;
        else if (stat_clr)
            stat_stall_cnt <= '0;
        else if (host_req && !host_ack && stat_stall_cnt != {STAT_W{1'b1}})
            stat_stall_cnt <= stat_stall_cnt + STAT_W'(1);
    end
`else
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - scoreboard bench for vga_fb_arbiter with a RAM model
module tb_vga_fb_arbiter;

    localparam int AW = 10;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_rvld;
    logic [DW-1:0] disp_rdata;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic          host_rvld;
    logic [DW-1:0] host_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
`ifdef VGA_FB_ARB_STAT_EN
    logic          stat_clr;
    logic [15:0]   stat_stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem     [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];
    logic [DW-1:0] disp_q[$];
    logic [DW-1:0] host_q[$];
    logic          prev_disp;
    logic          prev_hrd;
    int            w;
    logic [AW-1:0] a;

    vga_fb_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_rvld  (disp_rvld),
        .disp_rdata (disp_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rvld  (host_rvld),
        .host_rdata (host_rdata),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
`ifdef VGA_FB_ARB_STAT_EN
        ,
        .stat_clr       (stat_clr),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latency and data checks for both read ports, against bench-side expectations.
    always @(negedge clk) begin
        if (!rst_n) begin
            disp_q.delete();
            host_q.delete();
            prev_disp = 1'b0;
            prev_hrd  = 1'b0;
        end else begin
            chk("disp_lat", {31'b0, disp_rvld}, {31'b0, prev_disp});
            chk("host_lat", {31'b0, host_rvld}, {31'b0, prev_hrd});
            if (disp_rvld) begin
                if (disp_q.size() > 0)
                    chk("disp_data", {20'b0, disp_rdata}, {20'b0, disp_q.pop_front()});
                else
                    chk("disp_q_has_entry", disp_q.size(), 1);
            end
            if (host_rvld) begin
                if (host_q.size() > 0)
                    chk("host_data", {20'b0, host_rdata}, {20'b0, host_q.pop_front()});
                else
                    chk("host_q_has_entry", host_q.size(), 1);
            end
            prev_disp = disp_req;
            prev_hrd  = host_req && !host_we && host_ack;
        end
    end

    task automatic disp_drive(input logic on, input logic [AW-1:0] ad);
        disp_req  = on;
        disp_addr = ad;
        if (on)
            disp_q.push_back(ref_mem[ad]);
    endtask

    task automatic host_write(input logic [AW-1:0] ad, input logic [DW-1:0] d, output int waited);
        host_req = 1'b1; host_we = 1'b1; host_addr = ad; host_wdata = d;
        waited = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (host_ack) break;
            waited++;
            @(posedge clk); #1;
        end
        chk("wr_ack", {31'b0, host_ack}, 1);
        if (host_ack)
            ref_mem[ad] = d;
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] ad, output int waited);
        host_req = 1'b1; host_we = 1'b0; host_addr = ad;
        waited = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (host_ack) break;
            waited++;
            @(posedge clk); #1;
        end
        chk("rd_ack", {31'b0, host_ack}, 1);
        if (host_ack)
            host_q.push_back(ref_mem[ad]);
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = DW'(i);
            ref_mem[i] = DW'(i);
        end
        disp_req = 0; disp_addr = '0;
        host_req = 1; host_we = 1; host_addr = 10'h007; host_wdata = 12'h001;
`ifdef VGA_FB_ARB_STAT_EN
        stat_clr = 0;
`endif
        // Reset held: a pending write request must not be acknowledged
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'b0, host_ack}, 0);
        chk("rst_we", {31'b0, ram_we}, 0);
        chk("rst_drvld", {31'b0, disp_rvld}, 0);
        chk("rst_hrvld", {31'b0, host_rvld}, 0);
        @(posedge clk); #1;
        host_req = 0; host_we = 0; rst_n = 1;
        @(negedge clk);
        chk("idle_ack", {31'b0, host_ack}, 0);
        chk("idle_we", {31'b0, ram_we}, 0);

        // Display burst 0x010..0x013
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            a = 10'h010 + AW'(i);
            disp_drive(1'b1, a);
        end
        @(posedge clk); #1;
        disp_drive(1'b0, '0);
        repeat (2) @(posedge clk);
        #1;

        // Write then read-back of the top address
        host_write(10'h3FF, 12'hABC, w);
        chk("t3_wr_wait", w, 0);
        host_we = 1'b0; host_addr = 10'h3FF; host_req = 1'b1;
        @(negedge clk);
        chk("t3_drain_we", {31'b0, ram_we}, 1);
        chk("t3_drain_addr", {22'b0, ram_addr}, 32'h3FF);
        chk("t3_drain_din", {20'b0, ram_din}, 32'hABC);
        chk("t3_rd_not_c0", {31'b0, host_ack}, 0);
        @(posedge clk); #1;
        host_read(10'h3FF, w);
        @(posedge clk); #1;

        // Writes under continuous display traffic
        for (int i = 0; i < 8; i++) begin
            a = 10'h020 + AW'(i);
            disp_drive(1'b1, a);
            if (i == 0) begin
                host_req = 1; host_we = 1; host_addr = 10'h005; host_wdata = 12'h123;
            end else if (i == 1) begin
                host_addr = 10'h006; host_wdata = 12'h456;
            end
            @(negedge clk);
            if (i == 0) begin
                chk("t4_ack_c0", {31'b0, host_ack}, 1);
                ref_mem[10'h005] = 12'h123;
            end else begin
                chk("t4_full_stall", {31'b0, host_ack}, 0);
            end
            chk("t4_no_we", {31'b0, ram_we}, 0);
            @(posedge clk); #1;
        end
        disp_drive(1'b0, '0);
        @(negedge clk);
        chk("t4_drain_we", {31'b0, ram_we}, 1);
        chk("t4_drain_addr", {22'b0, ram_addr}, 32'h005);
        chk("t4_drain_din", {20'b0, ram_din}, 32'h123);
        chk("t4_refill_ack", {31'b0, host_ack}, 1);
        ref_mem[10'h006] = 12'h456;
        @(posedge clk); #1;
        host_req = 0;
        @(negedge clk);
        chk("t4_2nd_addr", {22'b0, ram_addr}, 32'h006);
        chk("t4_2nd_din", {20'b0, ram_din}, 32'h456);
        @(posedge clk); #1;

        // Back-to-back writes with the display idle
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                host_req = 1; host_we = 1;
                host_addr = 10'h100 + AW'(i); host_wdata = 12'h200 + DW'(i);
            end else begin
                host_req = 0;
            end
            @(negedge clk);
            if (i < 4) begin
                chk("t5_ack", {31'b0, host_ack}, 1);
                ref_mem[host_addr] = host_wdata;
            end
            if (i == 0) begin
                chk("t5_we_first", {31'b0, ram_we}, 0);
            end else begin
                chk("t5_we", {31'b0, ram_we}, 1);
                chk("t5_addr", {22'b0, ram_addr}, 32'h100 + i - 1);
                chk("t5_din", {20'b0, ram_din}, 32'h200 + i - 1);
            end
            @(posedge clk); #1;
        end
        host_read(10'h102, w);
        @(posedge clk); #1;

        // Reset while a write is buffered behind the display
        disp_drive(1'b1, 10'h030);
        host_req = 1; host_we = 1; host_addr = 10'h050; host_wdata = 12'h777;
        @(negedge clk);
        chk("t6_ack", {31'b0, host_ack}, 1);
        @(posedge clk); #1;
        disp_drive(1'b1, 10'h031);
        #1 rst_n = 0;
        @(negedge clk);
        chk("t6_rst_we", {31'b0, ram_we}, 0);
        chk("t6_rst_ack", {31'b0, host_ack}, 0);
        chk("t6_rst_rvld", {31'b0, disp_rvld}, 0);
        @(posedge clk); #1;
        disp_req = 0; host_req = 0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_we", {31'b0, ram_we}, 0);
        end
        @(posedge clk); #1;
        host_read(10'h050, w);
        @(posedge clk); #1;

`ifdef VGA_FB_ARB_STAT_EN
        stat_clr = 1;
        @(posedge clk); #1;
        stat_clr = 0;
        for (int i = 0; i < 5; i++) begin
            a = 10'h040 + AW'(i);
            disp_drive(1'b1, a);
            host_req = 1; host_we = 0; host_addr = 10'h060;
            @(negedge clk);
            chk("st_starved", {31'b0, host_ack}, 0);
            @(posedge clk); #1;
        end
        host_req = 0;
        disp_drive(1'b0, '0);
        @(negedge clk);
        chk("st_cnt5", {16'b0, stat_stall_cnt}, 5);
        @(posedge clk); #1;
        stat_clr = 1;
        @(posedge clk); #1;
        stat_clr = 0;
        @(negedge clk);
        chk("st_clr", {16'b0, stat_stall_cnt}, 0);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("disp_q_empty", disp_q.size(), 0);
        chk("host_q_empty", host_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
